// File: rtl/inv_key_schedule_if.sv
// Handshake bundle between the inverse key schedule and its requester/consumer.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         done;

  // Requester / round-key consumer side
  modport master (
    output start, key_in, key_ready,
    input  ready, round_key, round_idx, key_valid, done
  );

  // Key schedule side
  modport slave (
    input  start, key_in, key_ready,
    output ready, round_key, round_idx, key_valid, done
  );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: walks from the round-10 key back to the
// cipher key, one round key per accepted transfer.
// Byte k of a 32-bit word sits at bits [8k+7:8k]; rcon occupies byte 0.

// RotWord: byte order [b0 b1 b2 b3] -> [b1 b2 b3 b0].
module rot_word (
  input  logic [31:0] word,
  output logic [31:0] result
);
  assign result = {word[7:0], word[31:8]};
endmodule

// SubWord: AES S-box on each byte (GF(2^8) inverse followed by the affine map).
module sub_word (
  input  logic [31:0] word,
  output logic [31:0] result
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 gives the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    logic [7:0] b;
    r  = 8'h01;
    sq = x;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Substitute all four bytes independently.
  always_comb begin
    result = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      result[8*j +: 8] = sbox(word[8*j +: 8]);
    end
  end
endmodule

module inv_key_schedule (
  input  logic              clk,
  input  logic              rst,
  inv_key_schedule_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] key_q;
  logic [3:0]   idx_q;
  logic         transfer;
  logic [7:0]   rc;
  logic [31:0]  p3;
  logic [31:0]  p2;
  logic [31:0]  p1;
  logic [31:0]  p0;
  logic [31:0]  rot;
  logic [31:0]  sub;

  assign transfer = (state == RUN) && bus.key_ready;

  // Previous round words; P3 is formed first because P0 depends on it.
  assign p3 = key_q[127:96] ^ key_q[95:64];
  assign p2 = key_q[95:64]  ^ key_q[63:32];
  assign p1 = key_q[63:32]  ^ key_q[31:0];

  rot_word u_rot (.word(p3),  .result(rot));
  sub_word u_sub (.word(rot), .result(sub));

  assign p0 = key_q[31:0] ^ sub ^ {24'h0, rc};

  // Round constant looked up from the round index being undone.
  always_comb begin
    rc = 8'h00;
    case (idx_q)
      4'd10:   rc = 8'h36;
      4'd9:    rc = 8'h1b;
      4'd8:    rc = 8'h80;
      4'd7:    rc = 8'h40;
      4'd6:    rc = 8'h20;
      4'd5:    rc = 8'h10;
      4'd4:    rc = 8'h08;
      4'd3:    rc = 8'h04;
      4'd2:    rc = 8'h02;
      4'd1:    rc = 8'h01;
      default: rc = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: start only honoured in IDLE; leave RUN after round 0 is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (transfer && (idx_q == 4'd0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.ready     = (state == IDLE);
    bus.key_valid = (state == RUN);
    bus.done      = transfer && (idx_q == 4'd0);
  end

  // Key/index register: load on start, step back one round per transfer, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
      idx_q <= '0;
    end else if ((state == IDLE) && bus.start) begin
      key_q <= bus.key_in;
      idx_q <= 4'd10;
    end else if (transfer && (idx_q != 4'd0)) begin
      key_q <= {p3, p2, p1, p0};
      idx_q <= idx_q - 4'd1;
    end
  end

  assign bus.round_key = key_q;
  assign bus.round_idx = idx_q;
endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL have no parameters; AES-128 only, 10 rounds fixed.
REQ-002 clk  input  1  single clock; all state rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a backward expansion; accepted only when ready=1.
REQ-005 key_in  input  128  round-10 (last) round key; word i at bits [32i+31:32i], word 0 at [31:0].
REQ-006 ready  output  1  block idle, start will be accepted.
REQ-007 round_key  output  128  current round key, same word packing as key_in.
REQ-008 round_idx  output  4  round number of round_key, 10 down to 0.
REQ-009 key_valid  output  1  round_key/round_idx valid.
REQ-010 key_ready  input  1  consumer accepts round_key this cycle.
REQ-011 done  output  1  one-cycle pulse on the cycle the round-0 (cipher) key is accepted.

Function
REQ-012 States SHALL be IDLE and RUN only.
REQ-013 IDLE: ready=1, key_valid=0; start=1 SHALL register key_in into the key register, set round_idx=10 and move to RUN on that edge.
REQ-014 Latency: key_valid SHALL be 1 in the first cycle after start is accepted, presenting key_in unchanged with round_idx=10.
REQ-015 RUN: ready=0, key_valid=1; a transfer occurs in any cycle with key_valid=1 and key_ready=1.
REQ-016 On a transfer with round_idx=r>0, the next cycle SHALL present the round r-1 key with round_idx=r-1.
REQ-017 Inverse step, N = current key, P = previous key: P3=N3^N2; P2=N2^N1; P1=N1^N0; P0=N0^SubWord(RotWord(P3))^rcon(r).
REQ-018 RotWord and SubWord SHALL be the existing rot_word and sub_word blocks (combinational), applied to P3 exactly as the forward key_expansion block applies them to its word 3.
REQ-019 rcon(r) SHALL be the 32-bit word {24'h0, rc} with rc for r=10..1 = 36,1B,80,40,20,10,08,04,02,01 (hex), applied on the same lane as the forward key_expansion rcon input.
REQ-020 rcon SHALL be derived from round_idx by a lookup table, not a separately stored register.
REQ-021 Stall: key_valid=1 and key_ready=0 SHALL hold round_key and round_idx unchanged, for any number of cycles.
REQ-022 On a transfer with round_idx=0, done SHALL be 1 in that same cycle and the state SHALL return to IDLE on the next edge (ready=1, key_valid=0 next cycle).
REQ-023 A key is presented at most once per cycle; throughput is one round key per cycle with key_ready held high, 11 keys per run.
REQ-024 start while in RUN SHALL be ignored; an in-flight run is never restarted or corrupted.
REQ-025 start in the cycle after done (state IDLE) SHALL be accepted normally; no dead cycle beyond the IDLE cycle.
REQ-026 round_key SHALL hold its last value in IDLE; consumers qualify it only with key_valid.
REQ-027 round_idx SHALL never wrap below 0 or exceed 10.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, ready=1, key_valid=0, done=0, round_key=0, round_idx=0.
REQ-029 rst asserted mid-run SHALL abort the run; after rst deasserts, no residual key_valid or done appears and the next start behaves as from power-up.

Verification
REQ-030 FIPS-197 A.1: key_in = round-10 key of cipher key 2b7e1516 28aed2a6 abf71588 09cf4f3c, key_ready=1 -> 11 consecutive key_valid cycles, round_idx 10..0, final round_key = that cipher key, done high on round 0 only.
REQ-031 Round trip: random cipher key expanded forward through 10 key_expansion instances, round-10 key fed in -> every round_key(r) equals the forward round-r key for r=10..0.
REQ-032 Backpressure: key_ready random 50% -> same key sequence as REQ-030, each key held stable while stalled, done exactly once.
REQ-033 start pulsed at round_idx=5 -> ignored, sequence completes unchanged; start in cycle after done -> new run, key_valid next cycle with round_idx=10.
REQ-034 rst asserted at round_idx=3 -> immediately ready=1, key_valid=0, round_key=0, round_idx=0; no done pulse.
REQ-035 All-zero key_in -> correct inverse sequence per REQ-017 matching a reference model, exercising rcon at every round.
